// File: rtl/shape_pkg.sv
// Shared waveform-select type and quarter-wave sine table constants for the oscillator.
package shape_pkg;

    typedef enum logic [1:0] {
        SAWTOOTH = 2'd0,
        SQUARE   = 2'd1,
        TRIANGLE = 2'd2,
        SIN      = 2'd3
    } wave_shape;

    localparam int SINE_DEPTH = 256;
    localparam int SINE_W     = 16;
    localparam int WAVE_W     = 16;

    // Elaboration-time only: round(32767*sin(pi/2 * i/256)) via a Taylor series.
    function automatic logic [SINE_W-1:0] sine_entry(input int i);
        real x;
        real term;
        real acc;
        int  r;
        x    = 3.14159265358979323846 * $itor(i) / 512.0;
        term = x;
        acc  = x;
        for (int k = 1; k <= 10; k++) begin
            term = -term * x * x / $itor((2 * k) * (2 * k + 1));
            acc  = acc + term;
        end
        r = $rtoi(32767.0 * acc + 0.5);
        return SINE_W'(r);
    endfunction

endpackage

// File: rtl/sine_lut.sv
// Combinational quarter-wave sine table; the caller mirrors and negates.
module sine_lut
    import shape_pkg::*;
(
    input  logic [7:0]        index,
    output logic [SINE_W-1:0] value
);

    logic [SINE_W-1:0] rom [SINE_DEPTH];

    for (genvar i = 0; i < SINE_DEPTH; i++) begin : g_rom
        localparam logic [SINE_W-1:0] ENTRY = sine_entry(i);
        assign rom[i] = ENTRY;
    end

    assign value = rom[index];

endmodule

// File: rtl/oscillator.sv
// Single-voice oscillator: phase accumulator, waveform shaper, amplitude scaling with saturation.
module oscillator
    import shape_pkg::*;
#(
    parameter int WIDTH      = 24,
    parameter int CLK_HZ     = 50_000_000,
    parameter int INC_PER_HZ = 86
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    enable,
    input  logic [15:0]             freq,
    input  logic [WIDTH-1:0]        amplitude,
    input  wave_shape               shape,
    output logic signed [WIDTH-1:0] out
);

    localparam int PW = WAVE_W + WIDTH + 1;

    // INC_PER_HZ = 0 derives the step from the clock rate instead.
    localparam longint INC = (INC_PER_HZ > 0) ? longint'(INC_PER_HZ)
                           : ((longint'(1) << 32) + longint'(CLK_HZ / 2)) / longint'(CLK_HZ);
    localparam logic [31:0] INC32 = 32'(INC);

    localparam logic signed [PW-1:0] MAX_S = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] MIN_S = {{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    function automatic logic signed [WIDTH-1:0] saturate(input logic signed [PW-1:0] v);
        if (v > MAX_S)
            return MAX_S[WIDTH-1:0];
        else if (v < MIN_S)
            return MIN_S[WIDTH-1:0];
        else
            return v[WIDTH-1:0];
    endfunction

    logic [31:0]              phase_p0;
    logic [31:0]              step;
    logic [16:0]              tri_q;
    logic [7:0]               lut_index;
    logic [SINE_W-1:0]        lut_value;
    logic signed [WAVE_W-1:0] wave;
    logic signed [WAVE_W-1:0] w_p1;
    logic signed [PW-1:0]     prod;
    logic signed [PW-1:0]     scaled;

    assign step      = 32'(freq) * INC32;
    assign tri_q     = phase_p0[31:15];
    assign lut_index = phase_p0[30] ? ~phase_p0[29:22] : phase_p0[29:22];

    sine_lut u_sine_lut (
        .index (lut_index),
        .value (lut_value)
    );

    // Stage 0: phase accumulator, wraps modulo 2^32
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            phase_p0 <= '0;
        else if (enable)
            phase_p0 <= phase_p0 + step;
    end

    // Bit tricks: flipping the MSB subtracts 32768; 32767 - x equals {x[15], ~x[14:0]}.
    always_comb begin
        wave = '0;
        case (shape)
            SAWTOOTH: wave = {~phase_p0[31], phase_p0[30:16]};
            SQUARE:   wave = phase_p0[31] ? 16'sh8001 : 16'sh7FFF;
            TRIANGLE: wave = tri_q[16] ? {tri_q[15], ~tri_q[14:0]} : {~tri_q[15], tri_q[14:0]};
            SIN:      wave = phase_p0[31] ? -$signed(lut_value) : $signed(lut_value);
            default:  wave = '0;
        endcase
    end

    // Stage 1: normalized wave value
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            w_p1 <= '0;
        else
            w_p1 <= wave;
    end

    assign prod   = PW'(w_p1) * PW'($signed({1'b0, amplitude}));
    assign scaled = prod >>> 15;

    // Stage 2: scaled, saturated and gated sample
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            out <= '0;
        else
            out <= enable ? saturate(scaled) : '0;
    end

endmodule

// File: tb/tb_oscillator.sv
// Directed self-checking bench for the oscillator: reset, shapes at frozen phases, saturation, enable, wrap.
module tb_oscillator;
    import shape_pkg::*;

    localparam int WIDTH = 24;

    logic                    clk;
    logic                    rstn;
    logic                    enable;
    logic [15:0]             freq;
    logic [WIDTH-1:0]        amplitude;
    wave_shape               shape;
    logic signed [WIDTH-1:0] out;

    int checks = 0;
    int errors = 0;

    oscillator #(.WIDTH(WIDTH), .CLK_HZ(50_000_000), .INC_PER_HZ(86)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .enable    (enable),
        .freq      (freq),
        .amplitude (amplitude),
        .shape     (shape),
        .out       (out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish, got no end expected end");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic shape_at(input wave_shape s, input string tag, input longint exp);
        shape = s;
        tick(2);
        check(tag, out, exp);
    endtask

    longint a;
    longint e;
    int     cur, prev, start, pre_v, post_v, viol, high, diff;
    bit     seen;

    initial begin
        rstn      = 1'b1;
        enable    = 1'b1;
        freq      = 16'd0;
        amplitude = 24'd4000;
        shape     = SAWTOOTH;

        #1 rstn = 1'b0;
        #1 check("reset_async", out, 0);
        tick(3);
        check("reset_hold", out, 0);
        rstn = 1'b1;
        tick(1);
        check("release_clk1", out, 0);
        tick(1);
        check("release_saw", out, -4000);

        // Shape latency and values at phase 0
        shape = SQUARE;
        tick(1);
        check("square_lat1", out, -4000);
        tick(1);
        check("square_p0", out, 3999);
        shape_at(TRIANGLE, "tri_p0", -4000);
        shape_at(SIN, "sin_p0", 0);
        shape_at(SQUARE, "square_p0b", 3999);
        amplitude = 24'd8000;
        tick(1);
        check("amp_lat1", out, 7999);

        for (int n = 0; n < 20; n++) begin
            a = 64'd8388000 + 64'd100 * longint'(n);
            amplitude = 24'(a);
            tick(1);
            e = (32767 * a) >>> 15;
            if (e > 8388607) e = 8388607;
            check("sat_hi_ramp", out, e);
        end
        for (int n = 0; n < 12; n++) begin
            amplitude = 24'(64'd16776000 + 64'd100 * longint'(n));
            tick(1);
            check("sat_hi_top", out, 8388607);
        end
        amplitude = 24'hFFFFFF;
        tick(1);
        check("sat_hi_max", out, 8388607);

        // p = 125 * 4_300_000 = 537_500_000
        amplitude = 24'd4000;
        freq = 16'd50000;
        tick(125);
        freq = 16'd0;
        shape_at(SIN, "sin_n125", 2828);
        shape_at(SAWTOOTH, "saw_n125", -2999);
        shape_at(TRIANGLE, "tri_n125", -1998);
        shape_at(SQUARE, "square_n125", 3999);

        // p = 1_075_000_000
        freq = 16'd50000;
        tick(125);
        freq = 16'd0;
        shape_at(SAWTOOTH, "saw_n250", -1998);
        shape_at(TRIANGLE, "tri_n250", 4);
        shape_at(SIN, "sin_n250", 3999);
        shape_at(SAWTOOTH, "saw_n250b", -1998);

        enable = 1'b0;
        freq = 16'd50000;
        tick(1);
        check("disable_mute", out, 0);
        tick(50);
        check("disable_hold", out, 0);
        freq = 16'd0;
        enable = 1'b1;
        tick(1);
        check("reenable_resume", out, -1998);

        // p = 3_225_000_000
        freq = 16'd50000;
        tick(500);
        freq = 16'd0;
        shape_at(SAWTOOTH, "saw_n750", 2006);
        shape_at(SQUARE, "square_n750", -4000);
        shape_at(TRIANGLE, "tri_n750", -15);
        shape_at(SIN, "sin_n750", -4000);

        shape = SQUARE;
        amplitude = 24'd4000;
        tick(2);
        for (int n = 0; n < 20; n++) begin
            a = 64'd8388000 + 64'd100 * longint'(n);
            amplitude = 24'(a);
            tick(1);
            e = (-32767 * a) >>> 15;
            if (e < -8388608) e = -8388608;
            check("sat_lo_ramp", out, e);
        end
        amplitude = 24'hFFFFFF;
        tick(1);
        check("sat_lo_max", out, -8388608);

        shape = SAWTOOTH;
        amplitude = 24'd4000;
        freq = 16'd65535;
        tick(2);
        prev = out;
        seen = 1'b0;
        pre_v = 0;
        post_v = 0;
        for (int n = 0; n < 1000 && !seen; n++) begin
            tick(1);
            cur = out;
            if (cur < prev - 4000) begin
                seen = 1'b1;
                pre_v = prev;
                post_v = cur;
            end
            prev = cur;
        end
        check("saw_wrap_seen", longint'(seen), 1);
        check("saw_wrap_top", longint'(pre_v >= 3985), 1);
        check("saw_wrap_bottom", longint'(post_v <= -3985), 1);

        freq = 16'd400;
        start = out;
        prev = start;
        viol = 0;
        for (int n = 0; n < 2000; n++) begin
            tick(1);
            cur = out;
            if (cur < prev) viol++;
            prev = cur;
        end
        check("ramp_monotonic", viol, 0);
        check("ramp_rises", longint'(prev - start >= 100), 1);

        shape = SQUARE;
        freq = 16'd65535;
        tick(2);
        high = 0;
        for (int n = 0; n < 7620; n++) begin
            tick(1);
            if (out > 0) high++;
        end
        diff = (high > 3810) ? high - 3810 : 3810 - high;
        check("square_duty", longint'(diff <= 20), 1);

        @(posedge clk);
        #3 rstn = 1'b0;
        #1 check("reset_midrun", out, 0);
        @(posedge clk);
        #1;
        freq = 16'd0;
        shape = SAWTOOTH;
        amplitude = 24'd4000;
        enable = 1'b1;
        rstn = 1'b1;
        tick(1);
        check("rerelease_clk1", out, 0);
        tick(1);
        check("rerelease_saw", out, -4000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
